// File: rtl/regfile_wr_arbiter_if.sv
// regfile_wr_arbiter_if: requester handshake and register_file write-port bundle for regfile_wr_arbiter.
interface regfile_wr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 3
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      rf_we;
  logic [ADDR_W-1:0]         rf_wr_addr;
  logic [DATA_W-1:0]         rf_wr_data;
  logic [7:0]                wr_cnt;
  logic                      r0_drop;
  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, rf_we, rf_wr_addr, rf_wr_data, wr_cnt, r0_drop
  );
  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, rf_we, rf_wr_addr, rf_wr_data, wr_cnt, r0_drop
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: round-robin arbiter sharing the register_file write port among NUM_REQ requesters.
// Define REGFILE_R0_LOCK_EN to make register 0 read-only (grants to addr 0 are dropped and flagged on r0_drop).
module regfile_wr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  regfile_wr_arbiter_if.slave bus
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t             r_state;
  logic [PW-1:0]      r_ptr;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_data;
  logic [7:0]         r_cnt;
  logic               r_drop;
  logic [NUM_REQ-1:0] w_grant;
  logic [PW-1:0]      w_gidx;
  logic               w_found;
  logic [ADDR_W-1:0]  w_addr;
  logic [DATA_W-1:0]  w_data;
  logic               w_drop;
  logic               w_issue;
  logic [PW-1:0]      w_next;
  always_comb begin
    w_grant = '0;
    w_gidx  = '0;
    w_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = (int'(r_ptr) + k) % NUM_REQ;
      if (!w_found && bus.req_valid[j]) begin
        w_found    = 1'b1;
        w_gidx     = PW'(j);
        w_grant[j] = 1'b1;
      end
    end
  end
  assign w_addr = bus.req_addr[int'(w_gidx)*ADDR_W +: ADDR_W];
  assign w_data = bus.req_data[int'(w_gidx)*DATA_W +: DATA_W];
  assign w_next = (int'(w_gidx) == NUM_REQ-1) ? '0 : w_gidx + 1'b1;
`ifdef REGFILE_R0_LOCK_EN
  assign w_drop = w_found && (w_addr == '0);
`else
  assign w_drop = 1'b0;
`endif
  assign w_issue = w_found && !w_drop;
  // Grant is gated by reset so no handshake can complete while the block is held.
  assign bus.req_ready  = rst_n ? w_grant : '0;
  assign bus.rf_we      = (r_state == ISSUE);
  assign bus.rf_wr_addr = r_addr;
  assign bus.rf_wr_data = r_data;
  assign bus.wr_cnt     = r_cnt;
  assign bus.r0_drop    = r_drop;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_issue ? ISSUE : IDLE;
      r_drop  <= w_drop;
      if (w_found) r_ptr <= w_next;
      if (w_issue) begin
        r_addr <= w_addr;
        r_data <= w_data;
      end
      if (r_state == ISSUE && r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: directed self-checking bench for regfile_wr_arbiter.
module tb_regfile_wr_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  regfile_wr_arbiter_if #(.NUM_REQ(4), .DATA_W(16), .ADDR_W(3)) bus ();
  regfile_wr_arbiter #(.NUM_REQ(4), .DATA_W(16), .ADDR_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b1;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    #2 rst_n = 1'b0;
    bus.req_valid = 4'hF;
    tick;
    tick;
    chk("rst_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_we",    32'(bus.rf_we), 32'h0);
    chk("rst_addr",  32'(bus.rf_wr_addr), 32'h0);
    chk("rst_data",  32'(bus.rf_wr_data), 32'h0);
    chk("rst_cnt",   32'(bus.wr_cnt), 32'h0);
    chk("rst_drop",  32'(bus.r0_drop), 32'h0);
    rst_n = 1'b1;
    bus.req_valid = 4'b0001;
    bus.req_data[15:0] = 16'habcd;
    #1 chk("t2_ready", 32'(bus.req_ready), 32'h1);
    tick;
    bus.req_valid = '0;
`ifdef REGFILE_R0_LOCK_EN
    chk("t2_we",   32'(bus.rf_we), 32'h0);
    chk("t2_drop", 32'(bus.r0_drop), 32'h1);
`else
    chk("t2_we",   32'(bus.rf_we), 32'h1);
    chk("t2_addr", 32'(bus.rf_wr_addr), 32'h0);
    chk("t2_data", 32'(bus.rf_wr_data), 32'habcd);
    chk("t2_drop", 32'(bus.r0_drop), 32'h0);
`endif
    tick;
    chk("t2_we_off", 32'(bus.rf_we), 32'h0);
    chk("t2_drop_off", 32'(bus.r0_drop), 32'h0);
`ifdef REGFILE_R0_LOCK_EN
    chk("t2_cnt", 32'(bus.wr_cnt), 32'h0);
`else
    chk("t2_cnt", 32'(bus.wr_cnt), 32'h1);
`endif
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    bus.req_addr  = {3'd4, 3'd3, 3'd2, 3'd1};
    bus.req_data  = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
    bus.req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #1 chk("t3_ready", 32'(bus.req_ready), 32'h1 << (k % 4));
      tick;
      chk("t3_we",   32'(bus.rf_we), 32'h1);
      chk("t3_addr", 32'(bus.rf_wr_addr), 32'((k % 4) + 1));
      chk("t3_data", 32'(bus.rf_wr_data), 32'(16'h1000 + (k % 4)));
    end
    bus.req_valid = '0;
    tick;
    chk("t3_we_off", 32'(bus.rf_we), 32'h0);
    chk("t3_cnt",    32'(bus.wr_cnt), 32'd5);
    bus.req_valid = 4'b0010;
    #1 chk("t4_ready_a", 32'(bus.req_ready), 32'b0010);
    tick;
    bus.req_valid = 4'b1010;
    #1 chk("t4_ready_b", 32'(bus.req_ready), 32'b1000);
    tick;
    chk("t4_addr_b", 32'(bus.rf_wr_addr), 32'd4);
    chk("t4_data_b", 32'(bus.rf_wr_data), 32'h1003);
    #1 chk("t4_ready_c", 32'(bus.req_ready), 32'b0010);
    tick;
    chk("t4_we_c",   32'(bus.rf_we), 32'h1);
    chk("t4_addr_c", 32'(bus.rf_wr_addr), 32'd2);
    chk("t4_data_c", 32'(bus.rf_wr_data), 32'h1001);
    bus.req_valid = '0;
    tick;
    chk("t4_we_off", 32'(bus.rf_we), 32'h0);
    chk("t4_cnt",    32'(bus.wr_cnt), 32'd8);
    bus.req_addr[5:3]   = 3'd1;
    bus.req_data[31:16] = 16'h0123;
    bus.req_valid = 4'b0010;
    #1 chk("t5_ready", 32'(bus.req_ready), 32'b0010);
    tick;
    chk("t5_we",   32'(bus.rf_we), 32'h1);
    chk("t5_addr", 32'(bus.rf_wr_addr), 32'd1);
    bus.req_valid = 4'hF;
    #1 rst_n = 1'b0;
    #1 chk("t5_we_async", 32'(bus.rf_we), 32'h0);
    chk("t5_addr_rst",  32'(bus.rf_wr_addr), 32'h0);
    chk("t5_data_rst",  32'(bus.rf_wr_data), 32'h0);
    chk("t5_ready_rst", 32'(bus.req_ready), 32'h0);
    tick;
    chk("t5_we_hold", 32'(bus.rf_we), 32'h0);
    chk("t5_cnt_rst", 32'(bus.wr_cnt), 32'h0);
    rst_n = 1'b1;
    bus.req_addr = {3'd4, 3'd3, 3'd2, 3'd1};
    #1 chk("t5_ptr0", 32'(bus.req_ready), 32'b0001);
    repeat (300) tick;
    chk("sat_cnt", 32'(bus.wr_cnt), 32'd255);
    chk("sat_we",  32'(bus.rf_we), 32'h1);
    bus.req_valid = 4'b0001;
    bus.req_addr[2:0]  = 3'd0;
    bus.req_data[15:0] = 16'h5555;
    tick;
    bus.req_valid = 4'b0001;
    #1 chk("t6_ready", 32'(bus.req_ready), 32'b0001);
    tick;
    bus.req_valid = '0;
`ifdef REGFILE_R0_LOCK_EN
    chk("t6_we",   32'(bus.rf_we), 32'h0);
    chk("t6_drop", 32'(bus.r0_drop), 32'h1);
`else
    chk("t6_we",   32'(bus.rf_we), 32'h1);
    chk("t6_drop", 32'(bus.r0_drop), 32'h0);
    chk("t6_data", 32'(bus.rf_wr_data), 32'h5555);
`endif
    tick;
    chk("t6_drop_off", 32'(bus.r0_drop), 32'h0);
    chk("t6_cnt",      32'(bus.wr_cnt), 32'd255);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
